hazard_stall_ctrl: RTL
======================

Name: hazard_stall_ctrl

Overview:
- ID-stage hazard unit that pairs with the EX-stage forwarding unit.
- The forwarding unit resolves producer-to-consumer hazards by bypassing. This block covers the cases bypassing cannot resolve: load-use, pipeline-wide memory wait and taken-branch flush.
- It keeps a two-entry shadow of in-flight writers (EX, MEM) and drives PC/IF-ID hold, ID-EX bubble, IF-ID flush, plus a stall-cycle counter.

Parameters:
- REG_W, 3, register index width
- CNT_W, 16, width of saturating stall counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- id_valid  in  1  valid instruction in ID
- id_rs  in  REG_W  ID source A
- id_rt  in  REG_W  ID source B
- id_uses_rs  in  1  ID reads rs
- id_uses_rt  in  1  ID reads rt (R-format or store data)
- id_rd  in  REG_W  ID destination
- id_regwrite  in  1  ID writes register file
- id_memread  in  1  ID is a load
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle
- mem_busy  in  1  data memory not ready; whole pipeline must freeze
- pc_hold  out  1  hold PC and IF/ID register
- ifid_flush  out  1  replace IF/ID contents with NOP
- idex_bubble  out  1  load NOP into ID/EX
- pipe_freeze  out  1  freeze all pipeline registers
- stall_cnt  out  CNT_W  total stalled cycles, saturating

Behaviour:
- Reset (async, immediate): state=RUN; shadow EX/MEM valid=0, rd=0, ld=0; stall_cnt=0; all control outputs 0.
- Shadow update on each clk edge when not frozen:
  - MEM <= EX.
  - EX <= {id_valid & id_regwrite, id_rd, id_memread}, or invalid if this cycle asserts idex_bubble.
- Shadow update when frozen: both entries hold.
- Load-use hazard, combinational:
  - Condition: id_valid & ex_v & ex_ld & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
  - MEM-stage matches raise no hazard; forwarding covers them.
- States:
  - RUN:
    - mem_busy -> MEMWAIT.
    - Else ex_branch_taken -> FLUSH.
    - Else load-use -> LDSTALL.
    - Else stay in RUN.
  - LDSTALL: lasts exactly 1 cycle. pc_hold=1, idex_bubble=1. Next state RUN, but MEMWAIT if mem_busy.
  - MEMWAIT: pipe_freeze=1 and pc_hold=1 while mem_busy. On mem_busy=0, return to RUN in the same cycle; outputs are combinational on state and inputs.
  - FLUSH: ifid_flush=1, idex_bubble=1 for 1 cycle. Next state RUN.
- Output decode is Mealy for entry conditions: the stall/flush signals assert in the same cycle the condition is seen, not one cycle later. State registers only the multi-cycle tail and the counter.
- Priority among simultaneous events: mem_busy > ex_branch_taken > load-use.
  - A load-use hazard coincident with a taken branch is discarded; the ID instruction is flushed.
  - A load-use hazard coincident with mem_busy is re-evaluated after the freeze ends; the shadow is unchanged.
- Back-to-back load-use stalls: after the bubble, ex_v=0, so the hazard clears. At most one stall per load.
- stall_cnt increments by 1 on every cycle in which pc_hold or pipe_freeze is 1. It saturates at 2^CNT_W-1 and never wraps.
- Reset asserted mid-stall: all outputs drop asynchronously and the shadow is invalidated.
- id_valid=0: no hazard is raised, and a bubble (invalid entry) is loaded into the EX shadow.

Decomposition:
- Shared package holds:
  - state encoding: RUN=2'b00, LDSTALL=2'b01, MEMWAIT=2'b10, FLUSH=2'b11
  - REG_W
  - a writer-record typedef {v, rd, ld}
- One natural sub-module, `sat_counter` (CNT_W, inc, rst), reusable by the other performance counters.

Test Plan:
- Load-use: LD r3 in EX (ex_v=1, ex_ld=1, ex_rd=3), ID ADD uses rs=3 -> pc_hold=1, idex_bubble=1 for exactly 1 cycle; next cycle no hazard; stall_cnt=1.
- ALU producer: EX writer rd=3 with ld=0, ID rs=3 -> no stall; all control outputs 0.
- Store data: LD r5 in EX, ID store with id_uses_rt=1, rt=5, id_uses_rs=0 -> stall 1 cycle. Same stimulus with id_uses_rt=0 -> no stall.
- mem_busy high for 4 cycles during a load-use condition -> pipe_freeze=1 for 4 cycles, shadow unchanged; then 1 LDSTALL cycle; stall_cnt=5.
- Taken branch and load-use in the same cycle -> ifid_flush=1 and idex_bubble=1, pc_hold=0; EX shadow invalid next cycle.
- Reset asserted in MEMWAIT mid-cycle -> outputs 0 without waiting for a clock edge; stall_cnt=0; state=RUN. Saturation check with CNT_W=4: 20 stall cycles -> stall_cnt=15.

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared definitions for the ID-stage hazard/stall controller: state encoding,
// register index width and the in-flight writer record kept in the shadow.
package hazard_stall_ctrl_pkg;

  localparam int REG_W = 3;

  localparam logic [1:0] ST_RUN     = 2'b00;
  localparam logic [1:0] ST_LDSTALL = 2'b01;
  localparam logic [1:0] ST_MEMWAIT = 2'b10;
  localparam logic [1:0] ST_FLUSH   = 2'b11;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             ld;
  } writer_t;

  function automatic logic src_match(input logic             uses,
                                     input logic [REG_W-1:0] src,
                                     input logic [REG_W-1:0] rd);
    return uses && (src == rd);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping so long
// stall runs never read back as small numbers.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID-stage hazard unit: load-use stall, memory-wait freeze and taken-branch
// flush, with a two-entry shadow of in-flight writers and a stall counter.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_hold,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int SH_EX  = 0;
  localparam int SH_MEM = 1;

  writer_t    shadow_q [2];
  writer_t    id_entry;
  logic [1:0] state_q;
  logic [1:0] entry_state;
  logic [1:0] cur_state;
  logic       load_use;

  assign id_entry = '{v: id_valid && id_regwrite, rd: id_rd, ld: id_memread};

  // Only a load sitting in EX forces a stall; a MEM-stage producer is bypassed.
  assign load_use = id_valid && shadow_q[SH_EX].v && shadow_q[SH_EX].ld &&
                    (src_match(id_uses_rs, id_rs, shadow_q[SH_EX].rd) ||
                     src_match(id_uses_rt, id_rt, shadow_q[SH_EX].rd));

  always_comb begin
    entry_state = ST_RUN;
    if (mem_busy) begin
      entry_state = ST_MEMWAIT;
    end else if (ex_branch_taken) begin
      entry_state = ST_FLUSH;
    end else if (load_use) begin
      entry_state = ST_LDSTALL;
    end
  end

  // Single-cycle states fall back to RUN evaluation and MEMWAIT exits in the
  // same cycle mem_busy drops, so the active state is decided combinationally.
  always_comb begin
    cur_state = entry_state;
    case (state_q)
      ST_MEMWAIT: cur_state = mem_busy ? ST_MEMWAIT : entry_state;
      default:    cur_state = entry_state;
    endcase
  end

  assign pc_hold     = !rst && ((cur_state == ST_MEMWAIT) || (cur_state == ST_LDSTALL));
  assign pipe_freeze = !rst &&  (cur_state == ST_MEMWAIT);
  assign idex_bubble = !rst && ((cur_state == ST_LDSTALL) || (cur_state == ST_FLUSH));
  assign ifid_flush  = !rst &&  (cur_state == ST_FLUSH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_RUN;
      shadow_q[SH_EX]  <= '0;
      shadow_q[SH_MEM] <= '0;
    end else begin
      state_q <= cur_state;
      if (!pipe_freeze) begin
        shadow_q[SH_MEM] <= shadow_q[SH_EX];
        shadow_q[SH_EX]  <= idex_bubble ? writer_t'('0) : id_entry;
      end
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (pc_hold || pipe_freeze),
    .count(stall_cnt)
  );

endmodule
